// File: rtl/nf_pwm_ramp_pkg.sv
// nf_pwm_ramp shared settings: register offsets,
// CTRL bit positions and the ramp FSM state enum.
package nf_pwm_ramp_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_TARGET = 2'd1;
  localparam logic [1:0] REG_STEP   = 2'd2;
  localparam logic [1:0] REG_PRESC  = 2'd3;

  // CTRL write bits
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  // CTRL read bits
  localparam int CTRL_BUSY  = 0;
  localparam int CTRL_DONE  = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_UPDATE
  } state_e;

endpackage

// File: rtl/nf_pwm_ramp.sv
// PWM duty ramp: steps a PWM compare value toward TARGET by STEP every PRESC+2
// cycles. Ports: clk/resetn, bus addr/we/wd/rd, pwm_we/pwm_wd, sticky done.
import nf_pwm_ramp_pkg::*;

module nf_pwm_ramp #(
  parameter int pwm_width   = 8,
  parameter int presc_width = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        pwm_we,
  output logic [31:0] pwm_wd,
  output logic        done
);

  state_e                 state_q, state_d;
  logic [presc_width-1:0] cnt_q, cnt_d;
  logic [presc_width-1:0] presc_q, presc_d;
  logic [pwm_width-1:0]   cur_q, cur_d;
  logic [pwm_width-1:0]   target_q, target_d;
  logic [pwm_width-1:0]   step_q, step_d;
  logic                   done_q, done_d;

  logic [pwm_width-1:0]   step_eff;
  logic [pwm_width-1:0]   gap;
  logic [pwm_width-1:0]   nxt;
  logic                   wr_ctrl;
  logic                   start;
  logic                   abort;
  logic                   busy;
  logic                   unused_ok;

  assign unused_ok = ^{addr, wd};

  assign wr_ctrl = we && (addr[3:2] == REG_CTRL);
  assign start   = wr_ctrl && wd[CTRL_START];
  assign abort   = wr_ctrl && wd[CTRL_ABORT];
  assign busy    = (state_q != ST_IDLE);

  // Saturating move toward TARGET: compare against the
  // remaining gap so the add/sub can never wrap.
  always_comb begin
    step_eff = (step_q == '0) ? pwm_width'(1) : step_q;
    if (target_q > cur_q) begin
      gap = target_q - cur_q;
      nxt = (step_eff >= gap) ? target_q
                              : cur_q + step_eff;
    end else begin
      gap = cur_q - target_q;
      nxt = (step_eff >= gap) ? target_q
                              : cur_q - step_eff;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    presc_d  = presc_q;
    cur_d    = cur_q;
    target_d = target_q;
    step_d   = step_q;
    done_d   = done_q;

    if (we) begin
      unique case (addr[3:2])
        REG_TARGET: target_d = wd[pwm_width-1:0];
        REG_STEP:   step_d   = wd[pwm_width-1:0];
        REG_PRESC:  presc_d  = wd[presc_width-1:0];
        default:    ;
      endcase
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (target_q == cur_q) begin
            done_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            state_d = ST_WAIT;
            cnt_d   = presc_q;
          end
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_UPDATE;
        end else begin
          cnt_d = cnt_q - presc_width'(1);
        end
      end
      ST_UPDATE: begin
        // The write is already on the bus this cycle,
        // so cur tracks it even if aborted now.
        cur_d = nxt;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (nxt == target_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = presc_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      presc_q  <= '0;
      cur_q    <= '0;
      target_q <= '0;
      step_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      presc_q  <= presc_d;
      cur_q    <= cur_d;
      target_q <= target_d;
      step_q   <= step_d;
      done_q   <= done_d;
    end
  end

  assign pwm_we = (state_q == ST_UPDATE);
  assign pwm_wd = pwm_we ? 32'(nxt) : 32'(cur_q);
  assign done   = done_q;

  always_comb begin
    rd = '0;
    unique case (addr[3:2])
      REG_CTRL: begin
        rd[CTRL_BUSY] = busy;
        rd[CTRL_DONE] = done_q;
      end
      REG_TARGET: rd = 32'(target_q);
      REG_STEP:   rd = 32'(step_q);
      REG_PRESC:  rd = 32'(presc_q);
      default:    rd = '0;
    endcase
  end

endmodule

// File: tb/tb_nf_pwm_ramp.sv
// Scoreboard bench for nf_pwm_ramp: expected PWM writes
// (value and cycle) are queued; a monitor pops on pwm_we.
module tb_nf_pwm_ramp;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        pwm_we;
  logic [31:0] pwm_wd;
  logic        done;

  int   checks;
  int   fails;
  int   cyc;
  exp_t sb[$];

  nf_pwm_ramp #(
    .pwm_width  (8),
    .presc_width(16)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .addr  (addr),
    .we    (we),
    .wd    (wd),
    .rd    (rd),
    .pwm_we(pwm_we),
    .pwm_wd(pwm_wd),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  // Monitor: every pwm_we must match the queue head.
  always @(negedge clk) begin
    if (resetn && pwm_we) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pwm_we actual=%0d required=none cyc=%0d",
                 pwm_wd, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (pwm_wd !== 32'(e.val) || cyc != e.cyc) begin
          fails++;
          $display("FAIL pwm_write actual=%0d@%0d required=%0d@%0d",
                   pwm_wd, cyc, e.val, e.cyc);
        end
      end
    end
  end

  task automatic bus_wr(input logic [1:0] a,
                        input int d,
                        output int t0);
    @(negedge clk);
    addr = {28'd0, a, 2'b00};
    wd   = 32'(d);
    we   = 1'b1;
    t0   = cyc;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic bus_rd(input string name,
                        input logic [1:0] a,
                        input int exp);
    @(negedge clk);
    addr = {28'd0, a, 2'b00};
    we   = 1'b0;
    #1 chk(name, rd, 32'(exp));
  endtask

  task automatic push(input int v, input int c);
    exp_t e;
    e.val = v;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic setup(input int tg, input int st,
                       input int pr);
    int t;
    bus_wr(2'd1, tg, t);
    bus_wr(2'd2, st, t);
    bus_wr(2'd3, pr, t);
  endtask

  task automatic wait_done(input string name,
                           input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t0;
    checks = 0;
    fails  = 0;
    resetn = 1'b0;
    addr   = '0;
    we     = 1'b0;
    wd     = '0;
    #22 resetn = 1'b1;

    // Reset state
    bus_rd("rst_ctrl", 2'd0, 0);
    bus_rd("rst_target", 2'd1, 0);
    bus_rd("rst_presc", 2'd3, 0);
    chk("rst_pwm_wd", pwm_wd, 0);

    // 0 -> 10, step 3, presc 2: 3,6,9,10 every 4
    setup(10, 3, 2);
    bus_rd("rb_step", 2'd2, 3);
    bus_wr(2'd0, 1, t0);
    push(3, t0 + 4);
    push(6, t0 + 8);
    push(9, t0 + 12);
    push(10, t0 + 16);
    wait_done("ramp_up_done", 40);
    bus_rd("ramp_up_ctrl", 2'd0, 2);
    chk("ramp_up_cur", pwm_wd, 10);

    // 10 -> 255 in one saturating step
    setup(255, 250, 0);
    bus_wr(2'd0, 1, t0);
    push(255, t0 + 2);
    idle(6);
    chk("sat_top_done", 32'(done), 1);

    // TARGET == cur: no write, done, never busy
    bus_wr(2'd0, 1, t0);
    bus_rd("equal_ctrl", 2'd0, 2);
    idle(4);
    bus_rd("equal_ctrl2", 2'd0, 2);

    // 255 -> 200, then 200 -> 5 with STEP=0
    setup(200, 55, 0);
    bus_wr(2'd0, 1, t0);
    push(200, t0 + 2);
    idle(6);
    setup(5, 0, 0);
    bus_wr(2'd0, 1, t0);
    for (int i = 0; i < 195; i++)
      push(199 - i, t0 + 2 + 2 * i);
    wait_done("down_done", 500);
    chk("down_cur", pwm_wd, 5);

    // 5 -> 0 saturates at 0, no wrap
    setup(0, 10, 0);
    bus_wr(2'd0, 1, t0);
    push(0, t0 + 2);
    wait_done("zero_done", 20);

    // 0 -> 100 step 10 presc 5, abort after 3rd
    setup(100, 10, 5);
    bus_wr(2'd0, 1, t0);
    push(10, t0 + 7);
    push(20, t0 + 14);
    push(30, t0 + 21);
    while (cyc < t0 + 22) @(negedge clk);
    bus_wr(2'd0, 2, t0);
    idle(30);
    bus_rd("abort_ctrl", 2'd0, 0);
    chk("abort_cur", pwm_wd, 30);
    chk("abort_done", 32'(done), 0);

    // start+abort together from IDLE
    bus_wr(2'd0, 3, t0);
    bus_rd("sa_ctrl", 2'd0, 0);
    idle(10);

    // start during busy is ignored
    setup(50, 10, 1);
    bus_wr(2'd0, 1, t0);
    push(40, t0 + 3);
    push(50, t0 + 6);
    bus_wr(2'd0, 1, t0);
    wait_done("rest_done", 20);
    bus_rd("rest_ctrl", 2'd0, 2);

    // reset mid-WAIT
    setup(200, 1, 10);
    bus_wr(2'd0, 1, t0);
    idle(5);
    addr = 32'd0;
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_we", 32'(pwm_we), 0);
    chk("mid_rst_wd", pwm_wd, 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_rd", rd, 0);
    @(negedge clk);
    resetn = 1'b1;
    bus_rd("post_ctrl", 2'd0, 0);
    bus_rd("post_target", 2'd1, 0);
    bus_rd("post_step", 2'd2, 0);
    bus_rd("post_presc", 2'd3, 0);
    idle(20);
    chk("post_wd", pwm_wd, 0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/nf_pwm_ramp.md
NF_PWM_RAMP -- requirements
Module: nf_pwm_ramp

Interface
REQ-001 Parameter pwm_width, default 8, width of duty values (matches the PWM compare register it drives).
REQ-002 Parameter presc_width, default 16, width of the step-period prescaler.
REQ-003 clk  input  1  clock; the single clock for all logic.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 addr  input  32  bus address; only addr[3:2] decoded.
REQ-006 we  input  1  bus write enable, one write per cycle.
REQ-007 wd  input  32  bus write data.
REQ-008 rd  output  32  bus read data, combinational from addr.
REQ-009 pwm_we  output  1  write strobe to the PWM compare register.
REQ-010 pwm_wd  output  32  duty value to the PWM compare register, zero-extended from pwm_width.
REQ-011 done  output  1  sticky ramp-complete flag (interrupt level).

Function
REQ-012 Register map by addr[3:2]: 0 CTRL, 1 TARGET, 2 STEP, 3 PRESC; TARGET/STEP hold wd[pwm_width-1:0], PRESC holds wd[presc_width-1:0].
REQ-013 CTRL write: wd[0] start, wd[1] abort; CTRL read returns {30'b0, done, busy}, busy = state != IDLE.
REQ-014 Reads of TARGET/STEP/PRESC return the stored value zero-extended.
REQ-015 Internal register cur (pwm_width bits) holds the last duty written to the PWM.
REQ-016 FSM states IDLE, WAIT, UPDATE.
REQ-017 IDLE + start: done cleared; if TARGET == cur stay IDLE and set done next edge, no pwm_we; else go WAIT, prescale counter loaded with PRESC.
REQ-018 WAIT: counter decrements each cycle; at counter == 0 go UPDATE; WAIT lasts PRESC+1 cycles (PRESC = 0 gives 1 cycle).
REQ-019 UPDATE lasts exactly one cycle: pwm_we = 1, pwm_wd = nxt; cur <= nxt at the closing edge.
REQ-020 nxt = cur moved toward TARGET by STEP, saturating at TARGET (no overshoot, no wrap at 0 or 2^pwm_width-1); STEP = 0 is treated as 1.
REQ-021 After UPDATE: if nxt == TARGET go IDLE and set done; else go WAIT, counter reloaded with PRESC.
REQ-022 TARGET and STEP are sampled combinationally in UPDATE, PRESC at each reload; writes while busy take effect at the next such point.
REQ-023 First pwm_we occurs in cycle PRESC+2 after the start write edge; step period is PRESC+2 cycles.
REQ-024 Start while busy is ignored; abort while busy forces IDLE at next edge, no further pwm_we, cur held, done not set.
REQ-025 Simultaneous start and abort: abort wins; abort in IDLE has no effect.
REQ-026 pwm_we = 0 in every state other than UPDATE; pwm_wd = zero-extended cur outside UPDATE.

Reset
REQ-027 resetn low asynchronously forces state IDLE, cur 0, TARGET 0, STEP 0, PRESC 0, counter 0, done 0, pwm_we 0, pwm_wd 0.
REQ-028 Reset mid-ramp emits no further pwm_we; the attached PWM compare register is reset by its own reset, consistent with cur = 0.

Structure
REQ-029 Register offsets (CTRL/TARGET/STEP/PRESC), CTRL bit positions and the FSM state enum live in the shared settings package.
REQ-030 Single module, no sub-module; pwm_we/pwm_wd connect directly to the PWM's we/wd with its addr tied to its compare offset.

Verification
REQ-031 TARGET=10, STEP=3, PRESC=2, start from cur=0 -> pwm_we pulses with pwm_wd 3,6,9,10, 4 cycles apart, first in cycle 4; done=1 after the last.
REQ-032 cur=200, TARGET=5, STEP=0 (treated as 1), PRESC=0 -> 195 decrementing writes 199..5, one every 2 cycles, no wrap; done set.
REQ-033 cur=255, TARGET=255, start -> no pwm_we, done=1 next cycle, busy never 1.
REQ-034 Ramp 0->100 STEP=10 PRESC=5, abort after 3rd pwm_we -> no more pwm_we, cur=30, done=0, CTRL read = 0.
REQ-035 Start+abort same write from IDLE -> stays IDLE; start during busy -> ignored, ramp unchanged.
REQ-036 resetn low mid-WAIT -> all outputs 0 immediately; after release all registers read 0.
